// File: rtl/spike_train_decoder.sv
// spike_train_decoder: turns a raw neuron spike level into inter-spike
// intervals (queued in a small FIFO with a burst tag) and windowed spike rates.
// ISI and rate state advance only on ena cycles; FIFO pops are independent of ena.
module spike_train_decoder #(
  parameter int ISI_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_LOG2   = 10,
  parameter int CNT_W      = 8,
  parameter int BURST_ISI  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  output logic [ISI_W-1:0] isi_data,
  output logic             isi_burst,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic [CNT_W-1:0] rate_count,
  output logic             rate_valid,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  localparam logic [ISI_W-1:0] ISI_MAX   = '1;
  localparam logic [ISI_W-1:0] BURST_THR = ISI_W'(BURST_ISI);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // ---------------------------------------------------------------------------
  // Rising-edge event detection
  // ---------------------------------------------------------------------------
  logic spike_q;
  logic ev;

  // A level held across reset release still registers as an event because
  // spike_q restarts at 0.
  assign ev = ena & spike_in & ~spike_q;

  // Track the previous spike level, frozen while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n)   spike_q <= 1'b0;
    else if (ena) spike_q <= spike_in;
  end

  // ---------------------------------------------------------------------------
  // ISI FSM: the first event only arms the counter, later events push an ISI
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             push;

  // Next-state for the interval counter; saturates instead of wrapping.
  always_comb begin
    state_d = state_q;
    isi_d   = isi_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev) begin
          state_d = S_COUNT;
          isi_d   = ISI_W'(1);
        end
      end
      S_COUNT: begin
        if (ev) begin
          push  = 1'b1;
          isi_d = ISI_W'(1);
        end else if (ena && isi_q != ISI_MAX) begin
          isi_d = isi_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and interval counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      isi_q   <= '0;
    end else begin
      state_q <= state_d;
      isi_q   <= isi_d;
    end
  end

  // ---------------------------------------------------------------------------
  // ISI FIFO: {burst, isi} entries, pointers carry an extra wrap bit
  // ---------------------------------------------------------------------------
  logic [ISI_W:0] mem_q [FIFO_DEPTH];
  logic [AW:0]    wptr_q, rptr_q;
  logic           overflow_q;
  logic           empty, full, pop, wr_en, drop;
  logic [ISI_W:0] head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & isi_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;
  assign head  = mem_q[rptr_q[AW-1:0]];

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= {(isi_q <= BURST_THR), isi_q};
  end

  // Pointer and sticky-overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      if (drop)  overflow_q <= 1'b1;
    end
  end

  assign isi_valid = ~empty;
  assign isi_data  = empty ? '0 : head[ISI_W-1:0];
  assign isi_burst = ~empty & head[ISI_W];
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------------
  // Windowed spike rate
  // ---------------------------------------------------------------------------
  logic [WIN_LOG2-1:0] win_q;
  logic [CNT_W-1:0]    scnt_q, scnt_inc;
  logic [CNT_W-1:0]    rate_count_q;
  logic                rate_valid_q;
  logic                term;

  assign term     = ena && (win_q == '1);
  assign scnt_inc = (ev && scnt_q != CNT_MAX) ? scnt_q + 1'b1 : scnt_q;

  // An event on the terminal cycle still belongs to the closing window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q        <= '0;
      scnt_q       <= '0;
      rate_count_q <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      if (ena) begin
        if (term) begin
          rate_count_q <= scnt_inc;
          rate_valid_q <= 1'b1;
          scnt_q       <= '0;
          win_q        <= '0;
        end else begin
          win_q  <= win_q + 1'b1;
          scnt_q <= scnt_inc;
        end
      end
    end
  end

  assign rate_count = rate_count_q;
  assign rate_valid = rate_valid_q;

endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed bench for spike_train_decoder (ISI_W=16, DEPTH=4, WIN_LOG2=4).
module tb_spike_train_decoder;

  localparam int ISI_W = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, ena, spike_in, isi_ready;
  logic [ISI_W-1:0] isi_data;
  logic             isi_burst, isi_valid;
  logic [CNT_W-1:0] rate_count;
  logic             rate_valid, overflow;

  int checks = 0;
  int errors = 0;

  spike_train_decoder #(
    .ISI_W(ISI_W), .FIFO_DEPTH(4), .WIN_LOG2(4), .CNT_W(CNT_W), .BURST_ISI(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
    .isi_data(isi_data), .isi_burst(isi_burst), .isi_valid(isi_valid),
    .isi_ready(isi_ready), .rate_count(rate_count), .rate_valid(rate_valid),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // one clock: inputs applied now are sampled at the next edge, outputs read 1ns later
  task automatic drive(input logic s, input logic e);
    spike_in = s;
    ena      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    isi_ready = 1'b0;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // g-1 quiet enabled cycles followed by a one-cycle spike: ISI = g
  task automatic event_after(input int g);
    for (int i = 0; i < g - 1; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", isi_valid); end
    checks++; if (isi_data !== '0) begin errors++; $display("FAIL reset_data got %0d exp 0", isi_data); end
    checks++; if (rate_valid !== 1'b0 || rate_count !== '0) begin errors++; $display("FAIL reset_rate got %0d/%0d exp 0/0", rate_valid, rate_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", overflow); end
  endtask

  task automatic test_basic_isi();
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      drive((k == 10 || k == 30 || k == 35), 1'b1);
      if (k == 10) begin
        checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL first_ev_nopush got %0d exp 0", isi_valid); end
      end
      if (k == 30) begin
        checks++; if (isi_valid !== 1'b1 || isi_data !== 16'd20 || isi_burst !== 1'b0) begin
          errors++; $display("FAIL isi20 got v%0d d%0d b%0d exp v1 d20 b0", isi_valid, isi_data, isi_burst); end
      end
    end
    isi_ready = 1'b1; drive(1'b0, 1'b1); isi_ready = 1'b0;
    checks++; if (isi_valid !== 1'b1 || isi_data !== 16'd5 || isi_burst !== 1'b1) begin
      errors++; $display("FAIL isi5 got v%0d d%0d b%0d exp v1 d5 b1", isi_valid, isi_data, isi_burst); end
    isi_ready = 1'b1; drive(1'b0, 1'b1); isi_ready = 1'b0;
    checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0d exp 0", isi_valid); end
  endtask

  task automatic test_level();
    // level held high through reset release counts as an event
    rst_n = 1'b0; isi_ready = 1'b0;
    drive(1'b1, 1'b0); drive(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)  drive(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    checks++; if (isi_valid !== 1'b1 || isi_data !== 16'd14) begin
      errors++; $display("FAIL level_isi got v%0d d%0d exp v1 d14", isi_valid, isi_data); end
    isi_ready = 1'b1; drive(1'b0, 1'b1); isi_ready = 1'b0;
    checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL level_single got %0d exp 0", isi_valid); end
  endtask

  task automatic test_overflow();
    int exp_q [4] = '{3, 4, 5, 4};
    do_reset();
    drive(1'b1, 1'b1);
    for (int g = 2; g <= 5; g++) event_after(g);
    checks++; if (overflow !== 1'b0 || isi_data !== 16'd2) begin
      errors++; $display("FAIL full_no_ovf got o%0d d%0d exp o0 d2", overflow, isi_data); end
    event_after(6);
    event_after(7);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0d exp 1", overflow); end
    // push (ISI 4) and pop together while full
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    isi_ready = 1'b1; drive(1'b1, 1'b1); isi_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (isi_valid !== 1'b1 || isi_data !== 16'(exp_q[i])) begin
        errors++; $display("FAIL ovf_order[%0d] got v%0d d%0d exp v1 d%0d", i, isi_valid, isi_data, exp_q[i]); end
      isi_ready = 1'b1; drive(1'b0, 1'b1); isi_ready = 1'b0;
    end
    checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %0d exp 0", isi_valid); end
  endtask

  task automatic test_ena_gap();
    do_reset();
    drive(1'b1, 1'b1);
    for (int i = 0; i < 4; i++)  drive(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive((i < 5), 1'b0);
    for (int i = 0; i < 3; i++)  drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    checks++; if (isi_valid !== 1'b1 || isi_data !== 16'd8 || isi_burst !== 1'b1) begin
      errors++; $display("FAIL ena_gap got v%0d d%0d b%0d exp v1 d8 b1", isi_valid, isi_data, isi_burst); end
    event_after(9);
    isi_ready = 1'b1; drive(1'b0, 1'b1); isi_ready = 1'b0;
    checks++; if (isi_data !== 16'd9 || isi_burst !== 1'b0) begin
      errors++; $display("FAIL burst_edge got d%0d b%0d exp d9 b0", isi_data, isi_burst); end
  endtask

  task automatic test_rate();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive((k == 2 || k == 7 || k == 15), 1'b1);
      if (k == 14) begin
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL rate_early got %0d exp 0", rate_valid); end
      end
    end
    checks++; if (rate_valid !== 1'b1 || rate_count !== 8'd3) begin
      errors++; $display("FAIL rate_win1 got v%0d c%0d exp v1 c3", rate_valid, rate_count); end
    drive(1'b0, 1'b1);
    checks++; if (rate_valid !== 1'b0 || rate_count !== 8'd3) begin
      errors++; $display("FAIL rate_pulse got v%0d c%0d exp v0 c3", rate_valid, rate_count); end
    for (int k = 1; k < 16; k++) drive(1'b0, 1'b1);
    checks++; if (rate_valid !== 1'b1 || rate_count !== 8'd0) begin
      errors++; $display("FAIL rate_win2 got v%0d c%0d exp v1 c0", rate_valid, rate_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) event_after(3);
    checks++; if (isi_valid !== 1'b1 || isi_data !== 16'd3) begin
      errors++; $display("FAIL mid_queued got v%0d d%0d exp v1 d3", isi_valid, isi_data); end
    rst_n = 1'b0; drive(1'b0, 1'b1); rst_n = 1'b1;
    checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL mid_flush got %0d exp 0", isi_valid); end
    drive(1'b1, 1'b1);
    checks++; if (isi_valid !== 1'b0) begin errors++; $display("FAIL mid_first_ev got %0d exp 0", isi_valid); end
    event_after(3);
    checks++; if (isi_valid !== 1'b1 || isi_data !== 16'd3) begin
      errors++; $display("FAIL mid_resume got v%0d d%0d exp v1 d3", isi_valid, isi_data); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 1'b1);
    for (int i = 0; i < 70000; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    checks++; if (isi_valid !== 1'b1 || isi_data !== 16'd65535 || isi_burst !== 1'b0) begin
      errors++; $display("FAIL isi_sat got v%0d d%0d b%0d exp v1 d65535 b0", isi_valid, isi_data, isi_burst); end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; isi_ready = 1'b0;
    test_reset();
    test_basic_isi();
    test_level();
    test_overflow();
    test_ena_gap();
    test_rate();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
